shared_reg_write_arbiter: RTL and testbench

- Round-robin write arbiter/sequencer that shares one WIDTH-bit write-enabled register (Register1biten cells in parallel) between NREQ requesters.
- Drives the register's write_en and data_in; returns the register's data_out to requesters.
- Uses a req/gnt/ack handshake, so at most one requester writes per transaction.
- Sits between datapath requesters and the shared register bank.

---
 rtl/shared_reg_write_arbiter_pkg.sv | 15 +
 rtl/shared_reg_write_arbiter_rr_pick.sv | 32 +++
 rtl/shared_reg_write_arbiter.sv | 122 ++++++++++++
 tb/tb_shared_reg_write_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_reg_write_arbiter_pkg.sv
// Shared definitions for shared_reg_write_arbiter: FSM state encodings and default sizes.
package shared_reg_write_arbiter_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT  = 3'd1,
        ST_WRITE  = 3'd2,
        ST_DONE   = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

endpackage

// File: rtl/shared_reg_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr_i, wrapping modulo NREQ.
module shared_reg_write_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] onehot_o,
    output logic [PW-1:0]   idx_o,
    output logic            valid_o
);

    logic [PW:0] pos;

    // Walk offsets from farthest to nearest so the nearest set request is the last write.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        pos     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            pos = {1'b0, ptr_i} + (PW+1)'(i);
            if (pos >= (PW+1)'(NREQ))
                pos = pos - (PW+1)'(NREQ);
            if (req_i[pos[PW-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = pos[PW-1:0];
            end
        end
        onehot_o = valid_o ? (NREQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/shared_reg_write_arbiter.sv
// Round-robin req/gnt/ack sequencer sharing one write-enabled register among NREQ requesters.
// Optional SHREG_LOCK_EN adds a lock input and LOCKED state for back-to-back re-writes by one owner.
module shared_reg_write_arbiter
    import shared_reg_write_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef SHREG_LOCK_EN
    input  logic [NREQ-1:0]       lock,
`endif
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  reg_we,
    output logic [WIDTH-1:0]      reg_din,
    input  logic [WIDTH-1:0]      reg_dout,
    output logic [WIDTH-1:0]      rdata,
    output logic                  busy
);

    localparam int PW = $clog2(NREQ);

    state_t            state_q;
    logic [PW-1:0]     g_q, rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]   gnt_q, ack_q;
    logic              we_q;
    logic [WIDTH-1:0]  din_q, wsel;
    logic [NREQ-1:0]   pick_oh;
    logic [PW-1:0]     pick_idx;
    logic              pick_vld;

    shared_reg_write_arbiter_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req_i    (req),
        .ptr_i    (rr_ptr_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .valid_o  (pick_vld)
    );

    always_comb begin
        wsel = '0;
        for (int i = 0; i < NREQ; i++)
            if (g_q == PW'(i))
                wsel = wdata[i*WIDTH +: WIDTH];
    end

    // A locked re-write recomputes the same g+1, so the pointer holds still until release.
    assign rr_ptr_d = (g_q == PW'(NREQ - 1)) ? '0 : g_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            g_q      <= '0;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            we_q     <= 1'b0;
            din_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (pick_vld) begin
                    g_q     <= pick_idx;
                    gnt_q   <= pick_oh;
                    state_q <= ST_GRANT;
                end
                ST_GRANT: begin
                    din_q   <= wsel;
                    we_q    <= 1'b1;
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    we_q     <= 1'b0;
                    ack_q    <= gnt_q;
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= ST_DONE;
                end
                ST_DONE: if (!req[g_q]) begin
                    ack_q <= '0;
`ifdef SHREG_LOCK_EN
                    if (lock[g_q]) begin
                        state_q <= ST_LOCKED;
                    end else begin
                        gnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end
`else
                    gnt_q   <= '0;
                    state_q <= ST_IDLE;
`endif
                end
`ifdef SHREG_LOCK_EN
                ST_LOCKED: begin
                    if (req[g_q]) begin
                        state_q <= ST_GRANT;
                    end else if (!lock[g_q]) begin
                        gnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    gnt_q   <= '0;
                    ack_q   <= '0;
                    we_q    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign ack     = ack_q;
    assign reg_we  = we_q;
    assign reg_din = din_q;
    assign rdata   = reg_dout;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shared_reg_write_arbiter.sv
// Bench for shared_reg_write_arbiter: vector table, directed corner sequences, randomized scoreboard.
module tb_shared_reg_write_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
`ifdef SHREG_LOCK_EN
    logic [NREQ-1:0]       lock;
`endif
    logic [NREQ-1:0]       gnt, ack;
    logic                  reg_we, busy;
    logic [WIDTH-1:0]      reg_din, reg_dout, rdata;

    int checks = 0;
    int errors = 0;

    shared_reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wdata    (wdata),
`ifdef SHREG_LOCK_EN
        .lock     (lock),
`endif
        .gnt      (gnt),
        .ack      (ack),
        .reg_we   (reg_we),
        .reg_din  (reg_din),
        .reg_dout (reg_dout),
        .rdata    (rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Shared register bank model: write-enabled cells with their own reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         reg_dout <= '0;
        else if (reg_we) reg_dout <= reg_din;
    end

    typedef struct {
        logic [NREQ-1:0]       req;
        logic [NREQ*WIDTH-1:0] wdata;
        logic [NREQ-1:0]       gnt;
        logic [WIDTH-1:0]      dout;
    } vec_t;

    vec_t tv [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic int ref_pick(input logic [NREQ-1:0] r, input int ptr);
        int k;
        for (int o = 0; o < NREQ; o++) begin
            k = (ptr + o) % NREQ;
            if (((r >> k) & NREQ'(1)) != 0) return k;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int w);
        return (w < 0) ? '0 : (NREQ'(1) << w);
    endfunction

    function automatic logic [WIDTH-1:0] slice(input logic [NREQ*WIDTH-1:0] d, input int w);
        return WIDTH'(d >> (w * WIDTH));
    endfunction

    int               mptr, cd, cw, n, w;
    int               waitcnt [NREQ];
    logic [WIDTH-1:0] cdat;
    logic [NREQ-1:0]  prev_gnt;

    initial begin
        tv[0] = '{4'b0010, 32'h4433A511, 4'b0010, 8'hA5};
        tv[1] = '{4'b0011, 32'h00001E2F, 4'b0001, 8'h2F};
        tv[2] = '{4'b1001, 32'h7C000003, 4'b1000, 8'h7C};
        tv[3] = '{4'b1000, 32'h81000000, 4'b1000, 8'h81};
        tv[4] = '{4'b0110, 32'h00C3B400, 4'b0010, 8'hB4};
        tv[5] = '{4'b0101, 32'h005A0099, 4'b0100, 8'h5A};

        wdata = '0;
`ifdef SHREG_LOCK_EN
        lock = '0;
`endif
        rst = 1'b1;
        req = '0;
        step();
        chk("rst_gnt", gnt, 0);
        chk("rst_ack", ack, 0);
        chk("rst_we", reg_we, 0);
        chk("rst_din", reg_din, 0);
        chk("rst_busy", busy, 0);
        step();
        rst = 1'b0;

        // Single transactions walking the round-robin pointer.
        for (int v = 0; v < 6; v++) begin
            req = tv[v].req;
            wdata = tv[v].wdata;
            step();
            chk($sformatf("v%0d_gnt", v), gnt, tv[v].gnt);
            chk($sformatf("v%0d_busy", v), busy, 1);
            chk($sformatf("v%0d_we0", v), reg_we, 0);
            step();
            chk($sformatf("v%0d_we", v), reg_we, 1);
            chk($sformatf("v%0d_din", v), reg_din, tv[v].dout);
            step();
            chk($sformatf("v%0d_ack", v), ack, tv[v].gnt);
            chk($sformatf("v%0d_dout", v), rdata, tv[v].dout);
            chk($sformatf("v%0d_weoff", v), reg_we, 0);
            req = '0;
            step();
            chk($sformatf("v%0d_gntclr", v), gnt, 0);
            chk($sformatf("v%0d_ackclr", v), ack, 0);
            chk($sformatf("v%0d_idle", v), busy, 0);
        end

        // All four requesting: grants rotate 0,1,2,3,0.
        do_reset();
        wdata = 32'h44332211;
        req = '1;
        for (int t = 0; t < 5; t++) begin
            w = t % NREQ;
            n = 0;
            while (ack == 0 && n < 10) begin
                step();
                n++;
            end
            chk($sformatf("rr%0d_ack", t), ack, onehot(w));
            chk($sformatf("rr%0d_dout", t), rdata, 8'h11 * (w + 1));
            req[w] = 1'b0;
            step();
            req[w] = 1'b1;
        end
        req = '0;
        step();

        // req1 raised during requester-0 WRITE waits until req0 drops.
        req = 4'b0001;
        wdata = 32'h0000BB0A;
        step();
        chk("mid_gnt0", gnt, 4'b0001);
        step();
        req = 4'b0011;
        step();
        chk("mid_ack0", ack, 4'b0001);
        chk("mid_dout0", rdata, 8'h0A);
        step();
        step();
        chk("mid_hold", gnt, 4'b0001);
        req = 4'b0010;
        step();
        chk("mid_idle", gnt, 4'b0000);
        step();
        chk("mid_gnt1", gnt, 4'b0010);
        step();
        step();
        chk("mid_ack1", ack, 4'b0010);
        chk("mid_dout1", rdata, 8'hBB);
        req = '0;
        step();

        // Reset while in WRITE.
        req = 4'b0100;
        wdata = 32'h00EE0000;
        step();
        step();
        chk("rw_we", reg_we, 1);
        #2;
        rst = 1'b1;
        req = '0;
        #1;
        chk("rw_we_drop", reg_we, 0);
        chk("rw_gnt_drop", gnt, 0);
        chk("rw_ack_drop", ack, 0);
        chk("rw_busy_drop", busy, 0);
        step();
        rst = 1'b0;
        req = 4'b1010;
        wdata = 32'h99007700;
        step();
        chk("rw_ptr0", gnt, 4'b0010);
        step();
        step();
        chk("rw_dout", rdata, 8'h77);
        req = '0;
        step();

        // Requester drops req in GRANT: write completes, ack pulses once.
        req = 4'b0001;
        wdata = 32'h0000003C;
        step();
        chk("drop_gnt", gnt, 4'b0001);
        req = '0;
        step();
        chk("drop_we", reg_we, 1);
        step();
        chk("drop_ack", ack, 4'b0001);
        chk("drop_dout", rdata, 8'h3C);
        step();
        chk("drop_ackclr", ack, 0);
        chk("drop_gntclr", gnt, 0);
        chk("drop_idle", busy, 0);

`ifdef SHREG_LOCK_EN
        // Requester 2 locks and writes twice while requester 0 waits.
        do_reset();
        lock = 4'b0100;
        wdata = 32'h005A0077;
        req = 4'b0100;
        step();
        chk("lk_gnt2", gnt, 4'b0100);
        req = 4'b0101;
        step();
        step();
        chk("lk_ack1", ack, 4'b0100);
        chk("lk_dout1", rdata, 8'h5A);
        req = 4'b0001;
        step();
        chk("lk_locked_gnt", gnt, 4'b0100);
        chk("lk_locked_ack", ack, 0);
        wdata = 32'h00C30077;
        req = 4'b0101;
        step();
        step();
        step();
        chk("lk_ack2", ack, 4'b0100);
        chk("lk_dout2", rdata, 8'hC3);
        req = 4'b0001;
        step();
        chk("lk_hold", gnt, 4'b0100);
        lock = '0;
        step();
        chk("lk_release", gnt, 0);
        step();
        chk("lk_next0", gnt, 4'b0001);
        step();
        step();
        chk("lk_dout0", rdata, 8'h77);
        req = '0;
        step();
`endif

        // Randomized requesters against a transaction-level round-robin scoreboard.
        do_reset();
        mptr = 0;
        cd = -1;
        cw = 0;
        cdat = '0;
        prev_gnt = '0;
        for (int i = 0; i < NREQ; i++) waitcnt[i] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            step();
            chk("rnd_onehot", $countones(gnt) <= 1, 1);
            chk("rnd_acksub", ack & ~gnt, 0);
            if (prev_gnt == 0 && gnt != 0) begin
                cw = ref_pick(req, mptr);
                chk("rnd_pick", gnt, onehot(cw));
                if (cw >= 0) begin
                    cdat = slice(wdata, cw);
                    chk("rnd_starve", waitcnt[cw] <= NREQ - 1, 1);
                    for (int i = 0; i < NREQ; i++)
                        if (req[i] && i != cw) waitcnt[i]++;
                    waitcnt[cw] = 0;
                end
                cd = 2;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    chk("rnd_ack", ack, onehot(cw));
                    chk("rnd_dout", rdata, cdat);
                    mptr = (cw + 1) % NREQ;
                    cd = -1;
                end
            end
            prev_gnt = gnt;
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && ack[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && cyc < 540 && $urandom_range(0, 2) == 0) begin
                    wdata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                    waitcnt[i] = 0;
                    req[i] = 1'b1;
                end
            end
        end
        step();
        step();
        chk("rnd_drain_req", req, 0);
        chk("rnd_drain_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
